instr_encode_loader: RTL and testbench

- Encoder end of the control instruction decode path: it builds 32-bit RV32I instruction words from separate fields.
- Field sets arrive over a valid/ready handshake. Each legal set is encoded and written sequentially into instruction memory from BASE_ADDR.
- Used by the bench/boot path to load programs that the core's decoder later consumes.
- Its immediate-format code uses the same imm_src encoding the decoder produces.

---
 rtl/instr_fmt_pkg.sv | 25 ++
 rtl/instr_word_encoder.sv | 52 +++++
 rtl/instr_encode_loader.sv | 133 +++++++++++++
 tb/tb_instr_encode_loader.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fmt_pkg.sv
// Shared RV32I format definitions for the instruction encoder and the control decoder.
// imm_src codes match what the decoder produces for each immediate format.
package instr_fmt_pkg;

    typedef enum logic [2:0] {
        IMM_I     = 3'b000,
        IMM_B     = 3'b001,
        IMM_S     = 3'b010,
        IMM_SHAMT = 3'b011,
        IMM_U     = 3'b100,
        IMM_J     = 3'b101,
        IMM_R     = 3'b110
    } imm_src_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

endpackage

// File: rtl/instr_word_encoder.sv
// Combinational RV32I word builder: packs fields by immediate format and flags
// unusable field sets (reserved format code, odd branch/jump offsets).
module instr_word_encoder
    import instr_fmt_pkg::*;
(
    input  logic [6:0]  i_opcode,
    input  logic [2:0]  i_funct3,
    input  logic [6:0]  i_funct7,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [31:0] i_imm,
    input  logic [2:0]  i_imm_src,
    output logic [31:0] o_word,
    output logic        o_illegal
);

    always_comb begin
        o_word    = 32'h0;
        o_illegal = 1'b0;
        case (i_imm_src)
            IMM_I: begin
                o_word = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
            end
            IMM_B: begin
                o_word    = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                             i_imm[4:1], i_imm[11], i_opcode};
                o_illegal = i_imm[0];
            end
            IMM_S: begin
                o_word = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
            end
            IMM_SHAMT: begin
                o_word = {i_funct7, i_imm[4:0], i_rs1, i_funct3, i_rd, i_opcode};
            end
            IMM_U: begin
                o_word = {i_imm[31:12], i_rd, i_opcode};
            end
            IMM_J: begin
                o_word    = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
                o_illegal = i_imm[0];
            end
            IMM_R: begin
                o_word = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
            end
            default: begin
                o_illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_encode_loader.sv
// Program loader: accepts field sets over valid/ready, encodes them and writes
// the words sequentially into instruction memory from BASE_ADDR.
module instr_encode_loader
    import instr_fmt_pkg::*;
#(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic              i_finish,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [6:0]        i_opcode,
    input  logic [2:0]        i_funct3,
    input  logic [6:0]        i_funct7,
    input  logic [4:0]        i_rd,
    input  logic [4:0]        i_rs1,
    input  logic [4:0]        i_rs2,
    input  logic [31:0]       i_imm,
    input  logic [2:0]        i_imm_src,
    output logic              o_imem_we,
    output logic [ADDR_W-1:0] o_imem_addr,
    output logic [31:0]       o_imem_wdata,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_full,
    output logic              o_err,
    output logic [ADDR_W:0]   o_word_count
);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StDone
    } state_e;

    localparam logic [ADDR_W:0]   DepthCnt = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W-1:0] BasePtr  = BASE_ADDR[ADDR_W-1:0];

    state_e            r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_full;
    logic              r_err;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;

    logic [31:0] w_word;
    logic        w_illegal;
    logic        w_ready;
    logic        w_accept;

    instr_word_encoder u_encoder (
        .i_opcode  (i_opcode),
        .i_funct3  (i_funct3),
        .i_funct7  (i_funct7),
        .i_rd      (i_rd),
        .i_rs1     (i_rs1),
        .i_rs2     (i_rs2),
        .i_imm     (i_imm),
        .i_imm_src (i_imm_src),
        .o_word    (w_word),
        .o_illegal (w_illegal)
    );

    assign w_ready  = (r_state == StLoad) && !r_full;
    assign w_accept = i_in_valid && w_ready;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= StIdle;
            r_ptr   <= BasePtr;
            r_count <= '0;
            r_full  <= 1'b0;
            r_err   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= 32'h0;
        end else begin
            r_we <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_state <= StLoad;
                        r_ptr   <= BasePtr;
                        r_count <= '0;
                        r_full  <= 1'b0;
                        r_err   <= 1'b0;
                    end
                end
                StLoad: begin
                    // An illegal set still completes the handshake; it is only dropped.
                    if (w_accept) begin
                        if (w_illegal) begin
                            r_err <= 1'b1;
                        end else begin
                            r_we    <= 1'b1;
                            r_addr  <= r_ptr;
                            r_wdata <= w_word;
                            r_ptr   <= r_ptr + 1'b1;
                            r_count <= r_count + 1'b1;
                            r_full  <= ((r_count + 1'b1) == DepthCnt);
                        end
                    end
                    if (i_finish) begin
                        r_state <= StDone;
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign o_in_ready   = w_ready;
    assign o_imem_we    = r_we;
    assign o_imem_addr  = r_addr;
    assign o_imem_wdata = r_wdata;
    assign o_busy       = (r_state != StIdle);
    assign o_done       = (r_state == StDone);
    assign o_full       = r_full;
    assign o_err        = r_err;
    assign o_word_count = r_count;

endmodule

// File: tb/tb_instr_encode_loader.sv
// Self-checking bench for instr_encode_loader: directed vector table, multi-cycle
// corner sequences, and random field sets against an arithmetic encoding model.
module tb_instr_encode_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, finish, in_valid;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3, imm_src;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;

    logic        in_ready, imem_we, busy, done, full, err;
    logic [9:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [10:0] word_count;

    logic        in_ready4, we4, busy4, done4, full4, err4;
    logic [1:0]  addr4;
    logic [31:0] wdata4;
    logic [2:0]  count4;

    instr_encode_loader dut (
        .i_clk(clk), .i_reset(reset), .i_start(start), .i_finish(finish),
        .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_opcode(opcode), .i_funct3(funct3), .i_funct7(funct7),
        .i_rd(rd), .i_rs1(rs1), .i_rs2(rs2), .i_imm(imm), .i_imm_src(imm_src),
        .o_imem_we(imem_we), .o_imem_addr(imem_addr), .o_imem_wdata(imem_wdata),
        .o_busy(busy), .o_done(done), .o_full(full), .o_err(err),
        .o_word_count(word_count)
    );

    instr_encode_loader #(.ADDR_W(2), .DEPTH(4), .BASE_ADDR(0)) dut4 (
        .i_clk(clk), .i_reset(reset), .i_start(start), .i_finish(finish),
        .i_in_valid(in_valid), .o_in_ready(in_ready4),
        .i_opcode(opcode), .i_funct3(funct3), .i_funct7(funct7),
        .i_rd(rd), .i_rs1(rs1), .i_rs2(rs2), .i_imm(imm), .i_imm_src(imm_src),
        .o_imem_we(we4), .o_imem_addr(addr4), .o_imem_wdata(wdata4),
        .o_busy(busy4), .o_done(done4), .o_full(full4), .o_err(err4),
        .o_word_count(count4)
    );

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [2:0]  src;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[6];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        opcode  = v.op;
        funct3  = v.f3;
        funct7  = v.f7;
        rd      = v.rd;
        rs1     = v.rs1;
        rs2     = v.rs2;
        imm     = v.imm;
        imm_src = v.src;
    endtask

    // Reference encoding built from the RV32I bit positions with shifts and masks.
    function automatic logic [31:0] model_word(input logic [6:0] op, input logic [2:0] f3,
                                               input logic [6:0] f7, input logic [4:0] rd_a,
                                               input logic [4:0] rs1_a, input logic [4:0] rs2_a,
                                               input logic [31:0] im, input logic [2:0] src);
        logic [31:0] wop  = 32'(op);
        logic [31:0] wf3  = 32'(f3) << 12;
        logic [31:0] wf7  = 32'(f7) << 25;
        logic [31:0] wrd  = 32'(rd_a) << 7;
        logic [31:0] ws1  = 32'(rs1_a) << 15;
        logic [31:0] ws2  = 32'(rs2_a) << 20;
        case (src)
            3'd0: return ((im & 32'hFFF) << 20) | ws1 | wf3 | wrd | wop;
            3'd1: return (((im >> 12) & 32'h1) << 31) | (((im >> 5) & 32'h3F) << 25) | ws2
                         | ws1 | wf3 | (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 32'h1) << 7)
                         | wop;
            3'd2: return (((im >> 5) & 32'h7F) << 25) | ws2 | ws1 | wf3 | ((im & 32'h1F) << 7)
                         | wop;
            3'd3: return wf7 | ((im & 32'h1F) << 20) | ws1 | wf3 | wrd | wop;
            3'd4: return (im & 32'hFFFFF000) | wrd | wop;
            3'd5: return (((im >> 20) & 32'h1) << 31) | (((im >> 1) & 32'h3FF) << 21)
                         | (((im >> 11) & 32'h1) << 20) | (((im >> 12) & 32'hFF) << 12) | wrd
                         | wop;
            3'd6: return wf7 | ws2 | ws1 | wf3 | wrd | wop;
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit model_legal(input logic [2:0] src, input logic [31:0] im);
        return !(src == 3'd7 || ((src == 3'd1 || src == 3'd5) && im[0]));
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        v;
        int          exp_cnt;
        bit          exp_err;
        bit          acc;
        bit          legal;
        logic [31:0] exp_w;
        int          w4;
        logic [1:0]  a4[4];
        logic [31:0] last4;

        vecs[0] = '{7'b0010011, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5, 3'b000, 32'h00500093};
        vecs[1] = '{7'b1100011, 3'b000, 7'h00, 5'd0, 5'd1, 5'd2, 32'd8, 3'b001, 32'h00208463};
        vecs[2] = '{7'b0100011, 3'b010, 7'h00, 5'd0, 5'd1, 5'd2, 32'd12, 3'b010, 32'h0020A623};
        vecs[3] = '{7'b1101111, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'd2048, 3'b101,
                    32'h001000EF};
        vecs[4] = '{7'b0110111, 3'b000, 7'h00, 5'd5, 5'd0, 5'd0, 32'h12345000, 3'b100,
                    32'h123452B7};
        vecs[5] = '{7'b0010011, 3'b101, 7'b0100000, 5'd3, 5'd4, 5'd0, 32'd7, 3'b011,
                    32'h40725193};

        reset = 1'b1; start = 1'b0; finish = 1'b0; in_valid = 1'b0;
        drive(vecs[0]);
        repeat (2) @(negedge clk);
        check("rst_we", 32'(imem_we), 0);
        check("rst_addr", 32'(imem_addr), 0);
        check("rst_wdata", imem_wdata, 0);
        check("rst_count", 32'(word_count), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_full", 32'(full), 0);
        check("rst_err", 32'(err), 0);
        check("rst_ready", 32'(in_ready), 0);
        reset = 1'b0;

        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("start_busy", 32'(busy), 1);
        check("start_count", 32'(word_count), 0);

        // Directed table, back to back: one write per cycle at consecutive addresses.
        for (int i = 0; i < 6; i++) begin
            check($sformatf("vec%0d_ready", i), 32'(in_ready), 1);
            drive(vecs[i]);
            in_valid = 1'b1;
            @(negedge clk);
            check($sformatf("vec%0d_we", i), 32'(imem_we), 1);
            check($sformatf("vec%0d_addr", i), 32'(imem_addr), 32'(i));
            check($sformatf("vec%0d_wdata", i), imem_wdata, vecs[i].exp);
            check($sformatf("vec%0d_count", i), 32'(word_count), 32'(i + 1));
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("idle_we", 32'(imem_we), 0);

        // Reserved format and odd branch offset: accepted but dropped.
        drive(vecs[0]); imm_src = 3'b111; in_valid = 1'b1;
        check("src7_ready", 32'(in_ready), 1);
        @(negedge clk);
        check("src7_we", 32'(imem_we), 0);
        check("src7_err", 32'(err), 1);
        check("src7_count", 32'(word_count), 6);
        drive(vecs[1]); imm = 32'd5;
        check("bodd_ready", 32'(in_ready), 1);
        @(negedge clk);
        check("bodd_we", 32'(imem_we), 0);
        check("bodd_err", 32'(err), 1);
        check("bodd_count", 32'(word_count), 6);
        drive(vecs[0]);
        @(negedge clk);
        check("after_err_we", 32'(imem_we), 1);
        check("after_err_addr", 32'(imem_addr), 6);
        check("after_err_count", 32'(word_count), 7);

        // Final set together with finish: its write lands in the done cycle.
        drive(vecs[1]); finish = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; finish = 1'b0;
        check("fin_we", 32'(imem_we), 1);
        check("fin_addr", 32'(imem_addr), 7);
        check("fin_wdata", imem_wdata, 32'h00208463);
        check("fin_done", 32'(done), 1);
        check("fin_count", 32'(word_count), 8);
        @(negedge clk);
        check("post_fin_busy", 32'(busy), 0);
        check("post_fin_done", 32'(done), 0);
        check("post_fin_we", 32'(imem_we), 0);
        check("post_fin_ready", 32'(in_ready), 0);
        check("err_sticky", 32'(err), 1);

        start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("restart_err", 32'(err), 0);
        check("restart_count", 32'(word_count), 0);
        check("restart_busy", 32'(busy), 1);

        // Random field sets with idle gaps against the model.
        exp_cnt = 0;
        exp_err = 1'b0;
        for (int c = 0; c < 300; c++) begin
            opcode   = 7'($urandom);
            funct3   = 3'($urandom);
            funct7   = 7'($urandom);
            rd       = 5'($urandom);
            rs1      = 5'($urandom);
            rs2      = 5'($urandom);
            imm      = $urandom;
            imm_src  = 3'($urandom_range(0, 7));
            in_valid = ($urandom_range(0, 3) != 0);
            check("rnd_ready", 32'(in_ready), 1);
            acc   = in_valid;
            legal = model_legal(imm_src, imm);
            exp_w = model_word(opcode, funct3, funct7, rd, rs1, rs2, imm, imm_src);
            @(negedge clk);
            if (acc && legal) begin
                check("rnd_we", 32'(imem_we), 1);
                check("rnd_addr", 32'(imem_addr), 32'(exp_cnt));
                check("rnd_wdata", imem_wdata, exp_w);
                exp_cnt++;
            end else begin
                check("rnd_no_we", 32'(imem_we), 0);
            end
            if (acc && !legal) exp_err = 1'b1;
            check("rnd_count", 32'(word_count), 32'(exp_cnt));
            check("rnd_err", 32'(err), 32'(exp_err));
        end
        in_valid = 1'b0; finish = 1'b1;
        @(negedge clk); finish = 1'b0;
        check("rnd_done", 32'(done), 1);
        @(negedge clk);

        // Reset one cycle after an accept kills the pending session at once.
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        drive(vecs[2]); in_valid = 1'b1;
        @(posedge clk); #2;
        check("pre_rst_we", 32'(imem_we), 1);
        reset = 1'b1; #1;
        check("mid_rst_we", 32'(imem_we), 0);
        check("mid_rst_addr", 32'(imem_addr), 0);
        check("mid_rst_wdata", imem_wdata, 0);
        check("mid_rst_count", 32'(word_count), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_ready", 32'(in_ready), 0);
        @(negedge clk);
        check("mid_rst_we_hold", 32'(imem_we), 0);
        reset = 1'b0; in_valid = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        drive(vecs[3]); in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("rst_restart_we", 32'(imem_we), 1);
        check("rst_restart_addr", 32'(imem_addr), 0);
        check("rst_restart_wdata", imem_wdata, 32'h001000EF);
        check("rst_restart_count", 32'(word_count), 1);
        finish = 1'b1;
        @(negedge clk); finish = 1'b0;
        @(negedge clk);

        // DEPTH = 4 instance: five offered sets, only four written.
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        w4 = 0;
        last4 = 32'h0;
        for (int c = 0; c < 7; c++) begin
            if (c < 5) begin
                v = vecs[0];
                v.rd = 5'(c + 1);
                drive(v);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (we4) begin
                if (w4 < 4) a4[w4] = addr4;
                last4 = wdata4;
                w4++;
            end
            if (c == 3) begin
                check("d4_ready_after_4th", 32'(in_ready4), 0);
                check("d4_full_after_4th", 32'(full4), 1);
            end
        end
        check("d4_writes", 32'(w4), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < w4) check($sformatf("d4_addr%0d", i), 32'(a4[i]), 32'(i));
        end
        check("d4_last_wdata", last4, model_word(7'b0010011, 3'b000, 7'h00, 5'd4, 5'd0, 5'd0,
                                                 32'd5, 3'b000));
        check("d4_count", 32'(count4), 4);
        check("d4_full", 32'(full4), 1);
        check("d4_busy", 32'(busy4), 1);
        check("d4_err", 32'(err4), 0);
        finish = 1'b1;
        @(negedge clk); finish = 1'b0;
        check("d4_done", 32'(done4), 1);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
